// File: rtl/ps2_pkg.sv
// Shared register map, STATUS/CONTROL bit positions and RX FIFO entry layout
// for the PS/2 Avalon-MM register front-end.
package ps2_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_RSVD    = 2'd3;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_RXOVF     = 2;
  localparam int ST_TX_BUSY   = 3;
  localparam int ST_TXDONE    = 4;
  localparam int ST_TXFAIL    = 5;
  localparam int ST_TXREJ     = 6;
  localparam int ST_CNT_LSB   = 8;

  localparam int CTL_RX_IRQ_EN = 0;
  localparam int CTL_TX_IRQ_EN = 1;
  localparam int CTL_RX_EN     = 2;

  localparam int ENTRY_W = 9;

  // One FIFO entry: received byte plus its framing error flag.
  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rx_entry_t;

  // Sticky STATUS flags, grouped so checkers can bind to one signal.
  typedef struct packed {
    logic tx_rej;
    logic tx_fail;
    logic tx_done;
    logic rx_ovf;
  } sticky_t;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop in the same cycle frees a
// slot so a push to a full FIFO is still accepted.
module ps2_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_avalon_regs.sv
// Avalon-MM register front-end for ps2_core: RX FIFO, STATUS/CONTROL
// registers, sticky flags, TX request handshake and level interrupt.
module ps2_avalon_regs
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        irq,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_err,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic        tx_done,
  input  logic        tx_fail
);

  // Handshakes: Avalon reads have fixed latency 1 and writes are always
  // accepted. Toward the core, a DATA write becomes a one-cycle tx_start
  // request only when tx_busy is low and no request is already in flight
  // (tx_start low); otherwise it is dropped and TXREJ is set. tx_done and
  // tx_fail are one-cycle completion pulses from the core.

  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  rx_entry_t          head_entry;

  logic        rd_pop;
  logic        push_req;
  logic        set_ovf;
  logic        wr_data;
  logic        wr_status;
  logic        wr_control;
  logic        tx_accept;
  logic        tx_reject;
  logic [2:0]  ctrl;
  sticky_t     sticky;
  logic [31:0] status_word;
  logic [31:0] rd_mux;
  logic [23:0] unused_wdata;

  assign head_entry = rx_entry_t'(fifo_head);
  assign rd_pop     = avs_read && (avs_address == ADDR_DATA) && !fifo_empty;
  assign push_req   = rx_valid && ctrl[CTL_RX_EN];
  assign set_ovf    = push_req && fifo_full && !rd_pop;
  assign wr_data    = avs_write && (avs_address == ADDR_DATA);
  assign wr_status  = avs_write && (avs_address == ADDR_STATUS);
  assign wr_control = avs_write && (avs_address == ADDR_CONTROL);
  assign tx_accept  = wr_data && !tx_busy && !tx_start;
  assign tx_reject  = wr_data && !tx_accept;
  assign unused_wdata = avs_writedata[31:8];

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_rx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_req),
    .push_data ({rx_err, rx_data}),
    .pop       (rd_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    status_word                      = '0;
    status_word[ST_NOT_EMPTY]        = !fifo_empty;
    status_word[ST_FULL]             = fifo_full;
    status_word[ST_RXOVF]            = sticky.rx_ovf;
    status_word[ST_TX_BUSY]          = tx_busy;
    status_word[ST_TXDONE]           = sticky.tx_done;
    status_word[ST_TXFAIL]           = sticky.tx_fail;
    status_word[ST_TXREJ]            = sticky.tx_rej;
    status_word[ST_CNT_LSB +: 8]     = 8'(fifo_count);
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA:    if (!fifo_empty) rd_mux = {22'd0, head_entry.err, 1'b1, head_entry.data};
      ADDR_STATUS:  rd_mux = status_word;
      ADDR_CONTROL: rd_mux = {29'd0, ctrl};
      default:      rd_mux = '0;
    endcase
  end

  // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky       <= '0;
      ctrl         <= '0;
      tx_data      <= '0;
      tx_start     <= 1'b0;
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      sticky.rx_ovf  <= set_ovf | (sticky.rx_ovf & ~(wr_status & avs_writedata[ST_RXOVF]));
      sticky.tx_done <= tx_done | (sticky.tx_done & ~(wr_status & avs_writedata[ST_TXDONE]));
      sticky.tx_fail <= (tx_done & tx_fail) |
                        (sticky.tx_fail & ~(wr_status & avs_writedata[ST_TXFAIL]));
      sticky.tx_rej  <= tx_reject | (sticky.tx_rej & ~(wr_status & avs_writedata[ST_TXREJ]));
      if (wr_control) ctrl <= avs_writedata[2:0];
      if (tx_accept)  tx_data <= avs_writedata[7:0];
      tx_start     <= tx_accept;
      avs_readdata <= avs_read ? rd_mux : '0;
      irq          <= (ctrl[CTL_RX_IRQ_EN] & !fifo_empty) | (ctrl[CTL_TX_IRQ_EN] & sticky.tx_done);
    end
  end

endmodule

// File: tb/tb_ps2_avalon_regs.sv
// Bench for ps2_avalon_regs: directed vector table, a reset-mid-stream
// sequence, then random traffic against a queue-based reference model.
module tb_ps2_avalon_regs;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        irq;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_fail;

  int checks = 0;
  int errors = 0;

  ps2_avalon_regs #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .irq           (irq),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_err        (rx_err),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tx_fail       (tx_fail)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic        rxv;
    logic [7:0]  rxd;
    logic        rxe;
    logic        busy;
    logic        done;
    logic        fail;
    logic [31:0] exp_rd;
    logic        exp_irq;
    logic        exp_start;
    logic [7:0]  exp_txd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] addr, input logic rd, input logic wr, input logic [31:0] wdata,
                     input logic rxv, input logic [7:0] rxd, input logic rxe, input logic busy,
                     input logic done, input logic fail, input logic [31:0] exp_rd,
                     input logic exp_irq, input logic exp_start, input logic [7:0] exp_txd);
    vec_t v;
    v = '{addr, rd, wr, wdata, rxv, rxd, rxe, busy, done, fail, exp_rd, exp_irq, exp_start, exp_txd};
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic drive_idle();
    avs_address = 2'd0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    rx_valid = 1'b0; rx_data = '0; rx_err = 1'b0;
    tx_busy = 1'b0; tx_done = 1'b0; tx_fail = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0] mq[$];
  logic [2:0] m_ctrl;
  logic       m_ovf, m_done, m_fail, m_rej, m_start;
  logic [7:0] m_txd;

  task automatic model_reset();
    mq.delete();
    m_ctrl = '0; m_ovf = 0; m_done = 0; m_fail = 0; m_rej = 0; m_start = 0; m_txd = '0;
  endtask

  // Predicts outputs after the coming edge from current inputs, then advances.
  task automatic model_cycle(output logic [31:0] e_rd, output logic e_irq);
    logic       ovf_set, wr_ok, rej_set;
    logic [31:0] clr;
    int n;
    n = mq.size();
    e_irq = (m_ctrl[0] && n > 0) || (m_ctrl[1] && m_done);
    e_rd = '0;
    if (avs_read) begin
      case (avs_address)
        2'd0: if (n > 0) e_rd = {22'd0, mq[0][8], 1'b1, mq[0][7:0]};
        2'd1: e_rd = {16'd0, 8'(n), 1'b0, m_rej, m_fail, m_done, tx_busy, m_ovf, (n == DEPTH), (n > 0)};
        2'd2: e_rd = {29'd0, m_ctrl};
        default: e_rd = '0;
      endcase
    end
    if (avs_read && avs_address == 2'd0 && n > 0) void'(mq.pop_front());
    ovf_set = 1'b0;
    if (rx_valid && m_ctrl[2]) begin
      if (mq.size() < DEPTH) mq.push_back({rx_err, rx_data});
      else ovf_set = 1'b1;
    end
    wr_ok   = avs_write && avs_address == 2'd0 && !tx_busy && !m_start;
    rej_set = avs_write && avs_address == 2'd0 && !wr_ok;
    clr     = (avs_write && avs_address == 2'd1) ? avs_writedata : 32'd0;
    m_ovf  = ovf_set || (m_ovf && !clr[2]);
    m_done = tx_done || (m_done && !clr[4]);
    m_fail = (tx_done && tx_fail) || (m_fail && !clr[5]);
    m_rej  = rej_set || (m_rej && !clr[6]);
    if (avs_write && avs_address == 2'd2) m_ctrl = avs_writedata[2:0];
    if (wr_ok) m_txd = avs_writedata[7:0];
    m_start = wr_ok;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] e_rd;
    logic        e_irq;
    drive_idle();

    // Reset state and the basic RX path.
    for (int a = 0; a < 4; a++) add(2'(a), 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 8'h00);
    add(2'd2, 0, 1, 32'h5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    add(2'd0, 0, 0, 0, 1, 8'h1C, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    add(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    add(2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11C, 1, 0, 8'h00);
    add(2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 8'h00);
    // Overflow: 17 pushes into 16 entries.
    for (int i = 0; i < 17; i++) add(2'd0, 0, 0, 0, 1, 8'(i), 0, 0, 0, 0, 0, (i > 0), 0, 8'h00);
    add(2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1007, 1, 0, 8'h00);
    for (int i = 0; i < 16; i++) add(2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100 + i, 1, 0, 8'h00);
    add(2'd1, 0, 1, 32'h4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    add(2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 8'h00);
    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 16; i++) add(2'd0, 0, 0, 0, 1, 8'(8'h20 + i), 0, 0, 0, 0, 0, (i > 0), 0, 8'h00);
    add(2'd0, 1, 0, 0, 1, 8'hAA, 0, 0, 0, 0, 32'h120, 1, 0, 8'h00);
    add(2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1003, 1, 0, 8'h00);
    for (int i = 1; i < 16; i++) add(2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h120 + i, 1, 0, 8'h00);
    add(2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1AA, 1, 0, 8'h00);
    add(2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 8'h00);
    // TX handshake, rejects, done/fail, set-wins-over-clear.
    add(2'd2, 0, 1, 32'h7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    add(2'd0, 0, 1, 32'hED, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'hED);
    add(2'd0, 0, 1, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hED);
    add(2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'hED);
    add(2'd0, 0, 1, 32'h11, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'hED);
    add(2'd1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h48, 0, 0, 8'hED);
    add(2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 8'hED);
    add(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'hED);
    add(2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h70, 1, 0, 8'hED);
    add(2'd1, 0, 1, 32'h74, 0, 0, 0, 0, 1, 0, 0, 1, 0, 8'hED);
    add(2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10, 1, 0, 8'hED);
    add(2'd1, 0, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'hED);
    add(2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 8'hED);
    // rx_en off discards; reserved address.
    add(2'd2, 0, 1, 32'h3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hED);
    add(2'd0, 0, 0, 0, 1, 8'h77, 0, 0, 0, 0, 0, 0, 0, 8'hED);
    add(2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 8'hED);
    add(2'd3, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hED);
    add(2'd3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 8'hED);
    add(2'd2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3, 0, 0, 8'hED);

    do_reset();
    check("reset irq", {31'd0, irq}, 32'd0);
    check("reset tx_start", {31'd0, tx_start}, 32'd0);
    check("reset tx_data", {24'd0, tx_data}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      avs_address = vecs[i].addr; avs_read = vecs[i].rd; avs_write = vecs[i].wr;
      avs_writedata = vecs[i].wdata; rx_valid = vecs[i].rxv; rx_data = vecs[i].rxd;
      rx_err = vecs[i].rxe; tx_busy = vecs[i].busy; tx_done = vecs[i].done; tx_fail = vecs[i].fail;
      tick();
      if (vecs[i].rd) check($sformatf("vec%0d readdata", i), avs_readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
      check($sformatf("vec%0d tx_start", i), {31'd0, tx_start}, {31'd0, vecs[i].exp_start});
      check($sformatf("vec%0d tx_data", i), {24'd0, tx_data}, {24'd0, vecs[i].exp_txd});
    end
    drive_idle();

    // Reset in the middle of RX and TX activity.
    avs_address = 2'd2; avs_write = 1; avs_writedata = 32'h5; tick();
    drive_idle(); avs_address = 2'd2; avs_read = 1; rx_valid = 1; rx_data = 8'h5A; rx_err = 1; tick();
    check("pre-reset readdata", avs_readdata, 32'h5);
    drive_idle(); avs_address = 2'd0; avs_write = 1; avs_writedata = 32'h99; tick();
    check("pre-reset tx_start", {31'd0, tx_start}, 32'd1);
    check("pre-reset irq", {31'd0, irq}, 32'd1);
    drive_idle();
    #2 reset_n = 1'b0;
    #1;
    check("mid-reset readdata", avs_readdata, 32'h0);
    check("mid-reset irq", {31'd0, irq}, 32'd0);
    check("mid-reset tx_start", {31'd0, tx_start}, 32'd0);
    check("mid-reset tx_data", {24'd0, tx_data}, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    tick();
    avs_address = 2'd0; avs_read = 1; tick();
    check("post-reset DATA", avs_readdata, 32'h0);
    avs_address = 2'd1; tick();
    check("post-reset STATUS", avs_readdata, 32'h0);
    drive_idle();

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      avs_address   = 2'($urandom_range(0, 3));
      avs_read      = (r < 40);
      avs_write     = (r >= 40 && r < 58);
      avs_writedata = $urandom;
      if (avs_write && avs_address == 2'd2 && $urandom_range(0, 3) != 0) avs_writedata[2] = 1'b1;
      rx_valid = ($urandom_range(0, 99) < 45);
      rx_data  = 8'($urandom);
      rx_err   = ($urandom_range(0, 3) == 0);
      tx_busy  = ($urandom_range(0, 9) < 3);
      tx_done  = ($urandom_range(0, 9) == 0);
      tx_fail  = tx_done && ($urandom_range(0, 1) == 1);
      model_cycle(e_rd, e_irq);
      if (avs_read) exp_q.push_back(e_rd);
      tick();
      if (avs_read) check($sformatf("rand%0d readdata", c), avs_readdata, exp_q.pop_front());
      check($sformatf("rand%0d irq", c), {31'd0, irq}, {31'd0, e_irq});
      check($sformatf("rand%0d tx_start", c), {31'd0, tx_start}, {31'd0, m_start});
      check($sformatf("rand%0d tx_data", c), {24'd0, tx_data}, {24'd0, m_txd});
    end
    drive_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
